// File: rtl/if_fetch2_pkg.sv
// Shared definitions for the 2-wide fetch stage: widths, cb packet layout and FSM states.
package if_fetch2_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam int LINE_W = 2 * INST_W;
  localparam int PKT_W  = PC_W + INST_W;

  // Packet layout {pc, inst}: instruction in the low bits, its PC above it.
  localparam int PKT_INST_LO = 0;
  localparam int PKT_INST_HI = INST_W - 1;
  localparam int PKT_PC_LO   = INST_W;
  localparam int PKT_PC_HI   = PKT_W - 1;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch2_line_sel.sv
// Picks which half(s) of the held Imem line go to the cb this cycle and builds the packets.
module if_fetch2_line_sel
  import if_fetch2_pkg::*;
(
  input  logic              i_emit,
  input  logic [LINE_W-1:0] i_line,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_cb_full,
  input  logic              i_cb_full_almost,
  output logic [PKT_W-1:0]  o_din1,
  output logic [PKT_W-1:0]  o_din2,
  output logic              o_din1_en,
  output logic              o_din2_en,
  output logic [1:0]        o_n_used,
  output logic              o_line_done
);

  logic w_two_avail;

  // An odd-word PC means the lower half was already consumed (or skipped by a redirect).
  always_comb begin
    w_two_avail = !i_pc[2];
    o_din1_en   = i_emit && !i_cb_full;
    o_din2_en   = o_din1_en && w_two_avail && !i_cb_full_almost;
    o_n_used    = {1'b0, o_din1_en} + {1'b0, o_din2_en};
    o_line_done = o_din1_en && (o_din2_en || i_pc[2]);
    o_din1      = '0;
    o_din2      = '0;
    if (o_din1_en) begin
      o_din1[PKT_PC_HI:PKT_PC_LO]     = i_pc;
      o_din1[PKT_INST_HI:PKT_INST_LO] = i_pc[2] ? i_line[LINE_W-1:INST_W] : i_line[INST_W-1:0];
    end
    if (o_din2_en) begin
      o_din2[PKT_PC_HI:PKT_PC_LO]     = i_pc + PC_W'(4);
      o_din2[PKT_INST_HI:PKT_INST_LO] = i_line[LINE_W-1:INST_W];
    end
  end

endmodule

// File: rtl/if_fetch2.sv
// 2-wide instruction fetch: one Imem line per request, pushed into the cb as up to two packets.
module if_fetch2
  import if_fetch2_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_redirect_en,
  input  logic [PC_W-1:0]   i_redirect_pc,
  output logic              o_imem_req,
  output logic [PC_W-1:0]   o_imem_addr,
  input  logic              i_imem_valid,
  input  logic [LINE_W-1:0] i_imem_data,
  input  logic              i_cb_full,
  input  logic              i_cb_full_almost,
  output logic [PKT_W-1:0]  o_din1,
  output logic [PKT_W-1:0]  o_din2,
  output logic              o_din1_en,
  output logic              o_din2_en,
  output logic [PC_W-1:0]   o_fetch_pc
);

  fetch_state_e      r_state;
  logic [PC_W-1:0]   r_pc;
  logic [LINE_W-1:0] r_line;
  logic              r_line_v;

  logic       w_emit;
  logic [1:0] w_n_used;
  logic       w_line_done;

  assign w_emit      = (r_state == ST_HOLD) && r_line_v && !i_redirect_en;
  assign o_imem_req  = i_rst_n && (r_state == ST_REQ) && !i_redirect_en;
  assign o_imem_addr = {r_pc[PC_W-1:3], 3'b000};
  assign o_fetch_pc  = r_pc;

  if_fetch2_line_sel u_line_sel (
    .i_emit           (w_emit),
    .i_line           (r_line),
    .i_pc             (r_pc),
    .i_cb_full        (i_cb_full),
    .i_cb_full_almost (i_cb_full_almost),
    .o_din1           (o_din1),
    .o_din2           (o_din2),
    .o_din1_en        (o_din1_en),
    .o_din2_en        (o_din2_en),
    .o_n_used         (w_n_used),
    .o_line_done      (w_line_done)
  );

  // A redirect while a response is still owed parks in DROP; a response arriving that same cycle settles it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_REQ;
      r_pc     <= RESET_PC;
      r_line   <= '0;
      r_line_v <= 1'b0;
    end else if (i_redirect_en) begin
      r_pc     <= i_redirect_pc;
      r_line_v <= 1'b0;
      if ((r_state == ST_WAIT || r_state == ST_DROP) && !i_imem_valid)
        r_state <= ST_DROP;
      else
        r_state <= ST_REQ;
    end else begin
      case (r_state)
        ST_REQ: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (i_imem_valid) begin
            r_line   <= i_imem_data;
            r_line_v <= 1'b1;
            r_state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_pc <= r_pc + PC_W'({w_n_used, 2'b00});
          if (w_line_done) begin
            r_line_v <= 1'b0;
            r_state  <= ST_REQ;
          end
        end
        ST_DROP: begin
          if (i_imem_valid) r_state <= ST_REQ;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

endmodule
